irq_pending_latch: RTL and testbench
====================================

IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 Parameter: EDGE, default 1, capture mode (1 = rising-edge capture of req_in, 0 = level capture).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: clear  input  1  reset, synchronous, active-high.
REQ-004 Port: enable  input  1  capture and interrupt enable.
REQ-005 Port: req_in  input  8  raw request lines, bit 7 highest priority.
REQ-006 Port: mask  input  8  per-bit enable (1 = bit visible on pending and eligible for irq).
REQ-007 Port: ack  input  1  one-cycle service acknowledge.
REQ-008 Port: ack_idx  input  3  index of the bit being acknowledged (the downstream 8-to-3 priority encoder output).
REQ-009 Port: pending  output  8  registered masked pending vector; drives the priority encoder inputs.
REQ-010 Port: irq  output  1  registered interrupt request to the consumer.
REQ-011 Port: overrun  output  8  sticky per-bit flag: request lost because the bit was already pending.

Function
REQ-012 Internal raw pending register praw[7:0] and previous-sample register req_q[7:0]; req_q <= req_in every cycle, regardless of enable.
REQ-013 Set vector: EDGE=1 -> set = req_in & ~req_q; EDGE=0 -> set = req_in; set forced to 0 while enable=0.
REQ-014 Clear vector: clr = onehot(ack_idx) when ack=1, else 0; ack is honoured in every state and regardless of enable.
REQ-015 Update: praw <= (praw & ~clr) | set; same bit in set and clr in one cycle -> bit ends 1 (new event not lost).
REQ-016 Masked bits stay latched in praw; pending = registered praw & mask (one-cycle registered output); unmasking later exposes them.
REQ-017 Overrun: overrun[i] <= 1 when set[i]=1, praw[i]=1 and clr[i]=0; sticky until clear; never self-clears.
REQ-018 Latency: request edge sampled at edge N -> praw bit at N, pending bit at N+1, irq at N+2 earliest.
REQ-019 irq FSM states IDLE, ASSERT, GAP; irq=1 only in ASSERT.
REQ-020 IDLE -> ASSERT when enable=1 and |pending = 1; else stay.
REQ-021 ASSERT -> GAP on ack=1; ASSERT -> IDLE when enable=0 (irq drops next cycle); else stay.
REQ-022 GAP -> IDLE unconditionally after one cycle; guarantees >= 1 cycle irq low between services.
REQ-023 ack with ack_idx pointing at a 0 bit: no praw change, FSM still transitions as REQ-021.
REQ-024 irq re-asserts after GAP only if pending still non-zero (checked in IDLE).

Reset
REQ-025 clear=1 at a clock edge: praw=0, pending=0, req_q=0, overrun=0, state=IDLE, irq=0; clear dominates ack, set and enable.
REQ-026 Reset mid-service (ASSERT): irq=0 next cycle, all pending lost, no overrun recorded.
REQ-027 After reset with EDGE=1, a req_in bit held high through reset is captured as an edge on the first cycle after clear falls (req_q=0).

Verification
REQ-028 EDGE=1, mask=FF, enable=1, req_in 00->24 for one cycle -> pending=24 one cycle later, irq=1 next cycle; ack with ack_idx=5 -> pending=04, irq low one cycle (GAP), then irq=1 again.
REQ-029 Pending bit 3 set, second rising edge on bit 3 with no ack -> overrun=08, pending unchanged 08; overrun holds until clear.
REQ-030 Same cycle: ack, ack_idx=2, plus new edge on bit 2 -> bit 2 stays pending, irq passes GAP and re-asserts.
REQ-031 mask=00, req edge on bit 7 -> pending=00, irq=0; then mask=80 -> pending=80, irq=1 two cycles later.
REQ-032 enable=0 during req edges -> nothing captured; irq in ASSERT falls next cycle; clear asserted in ASSERT -> all outputs 0 next cycle.
REQ-033 EDGE=0, req_in=FF held -> pending=FF continuously; each ack cycles FSM ASSERT->GAP->IDLE->ASSERT, bits re-set each cycle, overrun stays 00 only if req deasserted before re-set of a still-pending bit (otherwise flags as REQ-017).

Source files
------------

// File: rtl/irq_pending_latch.sv
// Eight-line interrupt pending latch: edge or level capture, per-bit masking,
// sticky overrun flags and a registered irq handshake with a guaranteed low gap.
module irq_pending_latch #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] req_in,
  input  logic [7:0] mask,
  input  logic       ack,
  input  logic [2:0] ack_idx,
  output logic [7:0] pending,
  output logic       irq,
  output logic [7:0] overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] praw;
  logic [7:0] req_q;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;

  // A new event and an ack on the same bit leave the bit set, so nothing is lost.
  always_comb begin
    set_vec = 8'd0;
    clr_vec = 8'd0;
    if (enable) begin
      set_vec = EDGE ? (req_in & ~req_q) : req_in;
    end
    if (ack) begin
      clr_vec = 8'd1 << ack_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      req_q   <= 8'd0;
      praw    <= 8'd0;
      pending <= 8'd0;
      overrun <= 8'd0;
    end else begin
      req_q   <= req_in;
      praw    <= (praw & ~clr_vec) | set_vec;
      pending <= praw & mask;
      overrun <= overrun | (set_vec & praw & ~clr_vec);
    end
  end

  // GAP forces irq low while the acked bit drains out of the pending register.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable && (|pending)) begin
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (ack) begin
          state_nxt = GAP;
        end else if (!enable) begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      irq   <= 1'b0;
    end else begin
      state <= state_nxt;
      irq   <= (state_nxt == ASSERT);
    end
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: an edge-capture instance and a
// level-capture instance share stimulus; each scenario checks its own outputs.
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       clear;
  logic       enable;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_idx;
  logic [7:0] pending, overrun, pending_l, overrun_l;
  logic       irq, irq_l;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  irq_pending_latch #(.EDGE(1'b1)) dut (
    .clk(clk), .clear(clear), .enable(enable), .req_in(req_in), .mask(mask),
    .ack(ack), .ack_idx(ack_idx), .pending(pending), .irq(irq), .overrun(overrun)
  );

  irq_pending_latch #(.EDGE(1'b0)) dut_lvl (
    .clk(clk), .clear(clear), .enable(enable), .req_in(req_in), .mask(mask),
    .ack(ack), .ack_idx(ack_idx), .pending(pending_l), .irq(irq_l), .overrun(overrun_l)
  );

  // Outputs are observed 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; req_in = 8'h00; ack = 1'b0; ack_idx = 3'd0; enable = 1'b1; mask = 8'hFF;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; enable = 1'b1; mask = 8'hFF; req_in = 8'h01; ack = 1'b1; ack_idx = 3'd0;
    tick(); tick();
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_pending: got %h expected %h", pending, 8'h00); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_irq: got %b expected %b", irq, 1'b0); end
    tests_run++; if (overrun !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %h expected %h", overrun, 8'h00); end
    clear = 1'b0; ack = 1'b0;
    tick();
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL held_req_latency: got %h expected %h", pending, 8'h00); end
    tick();
    tests_run++; if (pending !== 8'h01) begin tests_failed++; $display("[TB] FAIL held_req_capture: got %h expected %h", pending, 8'h01); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL held_req_irq_early: got %b expected %b", irq, 1'b0); end
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL held_req_irq: got %b expected %b", irq, 1'b1); end
  endtask

  task automatic test_basic();
    do_clear();
    req_in = 8'h24; tick();
    req_in = 8'h00; tick();
    tests_run++; if (pending !== 8'h24) begin tests_failed++; $display("[TB] FAIL basic_pending: got %h expected %h", pending, 8'h24); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_irq_early: got %b expected %b", irq, 1'b0); end
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_irq: got %b expected %b", irq, 1'b1); end
    ack = 1'b1; ack_idx = 3'd5; tick();
    ack = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_gap_irq: got %b expected %b", irq, 1'b0); end
    tick();
    tests_run++; if (pending !== 8'h04) begin tests_failed++; $display("[TB] FAIL basic_after_ack: got %h expected %h", pending, 8'h04); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_idle_irq: got %b expected %b", irq, 1'b0); end
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_reassert: got %b expected %b", irq, 1'b1); end
    ack = 1'b1; ack_idx = 3'd2; tick();
    ack = 1'b0; tick(); tick();
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL basic_drained: got %h expected %h", pending, 8'h00); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_no_reassert: got %b expected %b", irq, 1'b0); end
    tests_run++; if (overrun !== 8'h00) begin tests_failed++; $display("[TB] FAIL basic_overrun: got %h expected %h", overrun, 8'h00); end
  endtask

  task automatic test_overrun();
    do_clear();
    req_in = 8'h08; tick();
    req_in = 8'h00; tick();
    req_in = 8'h08; tick();
    req_in = 8'h00; tick();
    tests_run++; if (overrun !== 8'h08) begin tests_failed++; $display("[TB] FAIL overrun_flag: got %h expected %h", overrun, 8'h08); end
    tests_run++; if (pending !== 8'h08) begin tests_failed++; $display("[TB] FAIL overrun_pending: got %h expected %h", pending, 8'h08); end
    ack = 1'b1; ack_idx = 3'd3; tick();
    ack = 1'b0; tick(); tick();
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL overrun_acked: got %h expected %h", pending, 8'h00); end
    tests_run++; if (overrun !== 8'h08) begin tests_failed++; $display("[TB] FAIL overrun_sticky: got %h expected %h", overrun, 8'h08); end
    do_clear();
    tests_run++; if (overrun !== 8'h00) begin tests_failed++; $display("[TB] FAIL overrun_cleared: got %h expected %h", overrun, 8'h00); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    req_in = 8'h04; tick();
    req_in = 8'h00; tick(); tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_irq: got %b expected %b", irq, 1'b1); end
    ack = 1'b1; ack_idx = 3'd2; req_in = 8'h04; tick();
    ack = 1'b0; req_in = 8'h00;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_gap: got %b expected %b", irq, 1'b0); end
    tests_run++; if (overrun !== 8'h00) begin tests_failed++; $display("[TB] FAIL b2b_overrun: got %h expected %h", overrun, 8'h00); end
    tick();
    tests_run++; if (pending !== 8'h04) begin tests_failed++; $display("[TB] FAIL b2b_pending: got %h expected %h", pending, 8'h04); end
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_reassert: got %b expected %b", irq, 1'b1); end
  endtask

  task automatic test_ack_zero_bit();
    do_clear();
    req_in = 8'h10; tick();
    req_in = 8'h00; tick(); tick();
    ack = 1'b1; ack_idx = 3'd0; tick();
    ack = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ackzero_gap: got %b expected %b", irq, 1'b0); end
    tick();
    tests_run++; if (pending !== 8'h10) begin tests_failed++; $display("[TB] FAIL ackzero_pending: got %h expected %h", pending, 8'h10); end
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL ackzero_reassert: got %b expected %b", irq, 1'b1); end
  endtask

  task automatic test_mask();
    do_clear();
    mask = 8'h00;
    req_in = 8'h80; tick();
    req_in = 8'h00; tick(); tick(); tick();
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL mask_hidden: got %h expected %h", pending, 8'h00); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL mask_irq: got %b expected %b", irq, 1'b0); end
    mask = 8'h80; tick();
    tests_run++; if (pending !== 8'h80) begin tests_failed++; $display("[TB] FAIL mask_exposed: got %h expected %h", pending, 8'h80); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL mask_irq_early: got %b expected %b", irq, 1'b0); end
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL mask_irq_late: got %b expected %b", irq, 1'b1); end
  endtask

  task automatic test_enable();
    do_clear();
    enable = 1'b0;
    req_in = 8'h10; tick();
    req_in = 8'h00; tick(); tick();
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL enable_blocked: got %h expected %h", pending, 8'h00); end
    enable = 1'b1;
    req_in = 8'h10; tick();
    req_in = 8'h00; tick(); tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL enable_irq: got %b expected %b", irq, 1'b1); end
    enable = 1'b0; tick();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL enable_drop: got %b expected %b", irq, 1'b0); end
    tests_run++; if (pending !== 8'h10) begin tests_failed++; $display("[TB] FAIL enable_kept: got %h expected %h", pending, 8'h10); end
    enable = 1'b1; tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL enable_resume: got %b expected %b", irq, 1'b1); end
    clear = 1'b1; req_in = 8'h10; ack = 1'b1; ack_idx = 3'd1; tick();
    clear = 1'b0; req_in = 8'h00; ack = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_irq: got %b expected %b", irq, 1'b0); end
    tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL clear_pending: got %h expected %h", pending, 8'h00); end
    tests_run++; if (overrun !== 8'h00) begin tests_failed++; $display("[TB] FAIL clear_overrun: got %h expected %h", overrun, 8'h00); end
  endtask

  task automatic test_level();
    do_clear();
    req_in = 8'h01; tick();
    req_in = 8'h00; tick();
    tests_run++; if (overrun_l !== 8'h00) begin tests_failed++; $display("[TB] FAIL level_no_overrun: got %h expected %h", overrun_l, 8'h00); end
    do_clear();
    req_in = 8'hFF; tick();
    tests_run++; if (overrun_l !== 8'h00) begin tests_failed++; $display("[TB] FAIL level_first_set: got %h expected %h", overrun_l, 8'h00); end
    tick();
    tests_run++; if (pending_l !== 8'hFF) begin tests_failed++; $display("[TB] FAIL level_pending: got %h expected %h", pending_l, 8'hFF); end
    tests_run++; if (overrun_l !== 8'hFF) begin tests_failed++; $display("[TB] FAIL level_overrun: got %h expected %h", overrun_l, 8'hFF); end
    tick();
    tests_run++; if (irq_l !== 1'b1) begin tests_failed++; $display("[TB] FAIL level_irq: got %b expected %b", irq_l, 1'b1); end
    ack = 1'b1; ack_idx = 3'd7; tick();
    ack = 1'b0;
    tests_run++; if (irq_l !== 1'b0) begin tests_failed++; $display("[TB] FAIL level_gap: got %b expected %b", irq_l, 1'b0); end
    tick();
    tests_run++; if (pending_l !== 8'hFF) begin tests_failed++; $display("[TB] FAIL level_reset_bit: got %h expected %h", pending_l, 8'hFF); end
    tests_run++; if (irq_l !== 1'b0) begin tests_failed++; $display("[TB] FAIL level_idle: got %b expected %b", irq_l, 1'b0); end
    tick();
    tests_run++; if (irq_l !== 1'b1) begin tests_failed++; $display("[TB] FAIL level_reassert: got %b expected %b", irq_l, 1'b1); end
  endtask

  initial begin
    clear = 1'b1; enable = 1'b0; req_in = 8'h00; mask = 8'h00; ack = 1'b0; ack_idx = 3'd0;
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_ack_zero_bit();
    test_mask();
    test_enable();
    test_level();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
